// File: rtl/video_timing_gen.sv
// Raster timing generator for the Green Beret core.
// Divides the 48 MHz master clock into a 1-in-8 pixel enable. Runs the PH/PV
// raster counters and derives blanking, sync and a vblank-start strobe from them.
// Sync position can be trimmed per frame via hoffs/voffs.
//
// Ports:
//   clk48M    in   master clock
//   reset     in   asynchronous active-high reset
//   hoffs     in   signed horizontal sync trim, -8..+7 pixels
//   voffs     in   signed vertical sync trim, -8..+7 lines
//   ce_pix    out  pixel clock enable, high 1 of 8 clk48M cycles
//   PH        out  horizontal pixel counter, 0..H_TOTAL-1
//   PV        out  vertical line counter, 0..V_TOTAL-1
//   hblank    out  horizontal blank (PH >= H_VIS)
//   vblank    out  vertical blank (PV >= V_VIS)
//   hsync     out  horizontal sync, trimmed by latched hoffs
//   vsync     out  vertical sync, trimmed by latched voffs
//   vbl_start out  one-cycle strobe when the raster enters PH=0, PV=V_VIS
module video_timing_gen #(
    parameter int unsigned H_TOTAL  = 384,
    parameter int unsigned H_VIS    = 256,
    parameter int unsigned HS_START = 288,
    parameter int unsigned HS_WIDTH = 32,
    parameter int unsigned V_TOTAL  = 264,
    parameter int unsigned V_VIS    = 224,
    parameter int unsigned VS_START = 240,
    parameter int unsigned VS_WIDTH = 8
) (
    input  logic       clk48M,
    input  logic       reset,
    input  logic [3:0] hoffs,
    input  logic [3:0] voffs,
    output logic       ce_pix,
    output logic [8:0] PH,
    output logic [8:0] PV,
    output logic       hblank,
    output logic       vblank,
    output logic       hsync,
    output logic       vsync,
    output logic       vbl_start
);

    localparam int unsigned DIV_W = 3;
    localparam int unsigned CNT_W = 9;
    localparam int unsigned OFF_W = 4;
    localparam int unsigned CMP_W = 10;

    // ce_pix is registered, so it is raised on the edge where div reads this value
    localparam logic [DIV_W-1:0] DIV_CE = DIV_W'(6);

    logic [DIV_W-1:0] div_q, div_d;
    logic             ce_q, ce_d;
    logic [CNT_W-1:0] ph_q, ph_d;
    logic [CNT_W-1:0] pv_q, pv_d;
    logic [OFF_W-1:0] hoff_q, hoff_d;
    logic [OFF_W-1:0] voff_q, voff_d;
    logic             hblank_q, hblank_d;
    logic             vblank_q, vblank_d;
    logic             hsync_q, hsync_d;
    logic             vsync_q, vsync_d;
    logic             vbl_start_q, vbl_start_d;

    logic             h_wrap;
    logic             v_wrap;

    logic signed [CMP_W-1:0] ph_s, pv_s;
    logic signed [CMP_W-1:0] hoff_s, voff_s;
    logic signed [CMP_W-1:0] hs_lo, hs_hi;
    logic signed [CMP_W-1:0] vs_lo, vs_hi;

    // Free-running pixel divider
    always_comb begin : divider_next
        div_d = div_q + DIV_W'(1);
        ce_d  = (div_q == DIV_CE);
    end

    // Raster counters; trims are latched only on the frame-boundary enable
    always_comb begin : counter_next
        ph_d   = ph_q;
        pv_d   = pv_q;
        hoff_d = hoff_q;
        voff_d = voff_q;
        h_wrap = (ph_q == CNT_W'(H_TOTAL - 1));
        v_wrap = (pv_q == CNT_W'(V_TOTAL - 1));
        if (ce_q) begin
            if (h_wrap) begin
                ph_d = '0;
                if (v_wrap) begin
                    pv_d   = '0;
                    hoff_d = hoffs;
                    voff_d = voffs;
                end else begin
                    pv_d = pv_q + CNT_W'(1);
                end
            end else begin
                ph_d = ph_q + CNT_W'(1);
            end
        end
    end

    // Sync windows in 10-bit signed space, using the trim that applies to the next position
    always_comb begin : sync_window
        ph_s   = $signed({1'b0, ph_d});
        pv_s   = $signed({1'b0, pv_d});
        hoff_s = $signed({{(CMP_W - OFF_W){hoff_d[OFF_W-1]}}, hoff_d});
        voff_s = $signed({{(CMP_W - OFF_W){voff_d[OFF_W-1]}}, voff_d});
        hs_lo  = $signed(CMP_W'(HS_START)) + hoff_s;
        hs_hi  = hs_lo + $signed(CMP_W'(HS_WIDTH));
        vs_lo  = $signed(CMP_W'(VS_START)) + voff_s;
        vs_hi  = vs_lo + $signed(CMP_W'(VS_WIDTH));
    end

    // Flags follow the next PH/PV so they line up with the counters they describe
    always_comb begin : flags_next
        hblank_d    = hblank_q;
        vblank_d    = vblank_q;
        hsync_d     = hsync_q;
        vsync_d     = vsync_q;
        vbl_start_d = 1'b0;
        if (ce_q) begin
            hblank_d    = (ph_d >= CNT_W'(H_VIS));
            vblank_d    = (pv_d >= CNT_W'(V_VIS));
            hsync_d     = (ph_s >= hs_lo) && (ph_s < hs_hi);
            vsync_d     = (pv_s >= vs_lo) && (pv_s < vs_hi);
            vbl_start_d = (ph_d == '0) && (pv_d == CNT_W'(V_VIS));
        end
    end

    // State registers
    always_ff @(posedge clk48M or posedge reset) begin : state_regs
        if (reset) begin
            div_q       <= '0;
            ce_q        <= 1'b0;
            ph_q        <= '0;
            pv_q        <= '0;
            hoff_q      <= '0;
            voff_q      <= '0;
            hblank_q    <= 1'b0;
            vblank_q    <= 1'b0;
            hsync_q     <= 1'b0;
            vsync_q     <= 1'b0;
            vbl_start_q <= 1'b0;
        end else begin
            div_q       <= div_d;
            ce_q        <= ce_d;
            ph_q        <= ph_d;
            pv_q        <= pv_d;
            hoff_q      <= hoff_d;
            voff_q      <= voff_d;
            hblank_q    <= hblank_d;
            vblank_q    <= vblank_d;
            hsync_q     <= hsync_d;
            vsync_q     <= vsync_d;
            vbl_start_q <= vbl_start_d;
        end
    end

    assign ce_pix    = ce_q;
    assign PH        = ph_q;
    assign PV        = pv_q;
    assign hblank    = hblank_q;
    assign vblank    = vblank_q;
    assign hsync     = hsync_q;
    assign vsync     = vsync_q;
    assign vbl_start = vbl_start_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen: a default-parameter instance (A) for line-level
// timing and async reset, and a reduced-raster instance (B) for frame-level
// behaviour, trim latching and vbl_start, checked against a cycle-count model.
module tb_video_timing_gen;

    // Reduced raster for instance B; sync windows stay in range for all trims
    localparam int BH_TOTAL  = 48;
    localparam int BH_VIS    = 32;
    localparam int BHS_START = 36;
    localparam int BHS_WIDTH = 4;
    localparam int BV_TOTAL  = 32;
    localparam int BV_VIS    = 20;
    localparam int BVS_START = 22;
    localparam int BVS_WIDTH = 2;
    localparam int BFRAME    = BH_TOTAL * BV_TOTAL * 8;

    typedef struct {
        int   ph;
        int   pv;
        logic hb;
        logic vb;
        logic hs;
        logic vs;
        logic vbs;
    } a_vec_t;

    typedef struct {
        int   fr;
        int   ph;
        int   pv;
        logic hb;
        logic vb;
        logic hs;
        logic vs;
        logic vbs;
    } b_vec_t;

    logic       clk = 1'b0;
    logic       rst_a, rst_b;
    logic [3:0] hoffs_a, voffs_a, hoffs_b, voffs_b;
    logic       ce_a, hb_a, vb_a, hs_a, vs_a, vbs_a;
    logic       ce_b, hb_b, vb_b, hs_b, vs_b, vbs_b;
    logic [8:0] ph_a, pv_a, ph_b, pv_b;

    int total = 0;
    int bad   = 0;
    int t_a   = 0;
    int t_b   = 0;
    int mh    = 0;
    int mv    = 0;
    int vbs_cnt = 0;

    a_vec_t av[9];
    b_vec_t bv[14];

    always #5 clk = ~clk;

    video_timing_gen u_a (
        .clk48M   (clk),
        .reset    (rst_a),
        .hoffs    (hoffs_a),
        .voffs    (voffs_a),
        .ce_pix   (ce_a),
        .PH       (ph_a),
        .PV       (pv_a),
        .hblank   (hb_a),
        .vblank   (vb_a),
        .hsync    (hs_a),
        .vsync    (vs_a),
        .vbl_start(vbs_a)
    );

    video_timing_gen #(
        .H_TOTAL (BH_TOTAL),
        .H_VIS   (BH_VIS),
        .HS_START(BHS_START),
        .HS_WIDTH(BHS_WIDTH),
        .V_TOTAL (BV_TOTAL),
        .V_VIS   (BV_VIS),
        .VS_START(BVS_START),
        .VS_WIDTH(BVS_WIDTH)
    ) u_b (
        .clk48M   (clk),
        .reset    (rst_b),
        .hoffs    (hoffs_b),
        .voffs    (voffs_b),
        .ce_pix   (ce_b),
        .PH       (ph_b),
        .PV       (pv_b),
        .hblank   (hb_b),
        .vblank   (vb_b),
        .hsync    (hs_b),
        .vsync    (vs_b),
        .vbl_start(vbs_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Advance instance A to the edge where it reaches pixel index k, sample 1 ns later
    task automatic a_goto(input int k);
        repeat (8 * k - t_a) @(posedge clk);
        t_a = 8 * k;
        #1;
    endtask

    // One clock of instance B, compared at the falling edge against a model
    // derived purely from the number of edges since reset release
    task automatic step_b();
        logic [3:0]  pend_h, pend_v;
        logic [23:0] exp_v, act_v;
        int          k, eph, epv;
        logic        ece, ehb, evb, ehs, evs, evbs;
        pend_h = hoffs_b;
        pend_v = voffs_b;
        @(posedge clk);
        if (rst_b) begin
            t_b = 0;
            mh  = 0;
            mv  = 0;
        end else begin
            t_b++;
            if (t_b % BFRAME == 0) begin
                mh = int'($signed(pend_h));
                mv = int'($signed(pend_v));
            end
        end
        @(negedge clk);
        k    = t_b / 8;
        eph  = k % BH_TOTAL;
        epv  = (k / BH_TOTAL) % BV_TOTAL;
        ece  = (t_b % 8 == 7);
        ehb  = (eph >= BH_VIS);
        evb  = (epv >= BV_VIS);
        ehs  = (eph >= BHS_START + mh) && (eph < BHS_START + mh + BHS_WIDTH);
        evs  = (epv >= BVS_START + mv) && (epv < BVS_START + mv + BVS_WIDTH);
        evbs = (t_b > 0) && (t_b % 8 == 0) && (eph == 0) && (epv == BV_VIS);
        exp_v = {ece, ehb, evb, ehs, evs, evbs, 9'(eph), 9'(epv)};
        act_v = {ce_b, hb_b, vb_b, hs_b, vs_b, vbs_b, ph_b, pv_b};
        if (vbs_b === 1'b1) vbs_cnt++;
        total++;
        if (act_v !== exp_v) begin
            bad++;
            $display("FAIL b_model t=%0d actual=%h required=%h", t_b, act_v, exp_v);
        end
    endtask

    task automatic b_goto(input int tgt);
        while (t_b < tgt) step_b();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int exp_vbs;
        av[0] = '{255, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        av[1] = '{256, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        av[2] = '{287, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        av[3] = '{288, 0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        av[4] = '{319, 0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        av[5] = '{320, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        av[6] = '{383, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        av[7] = '{0,   1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        av[8] = '{288, 1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};

        // frame 0 uses trim 0; frame 1 uses hoff=-8, voff=+7
        bv[0]  = '{0, 0,  20, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        bv[1]  = '{0, 0,  22, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        bv[2]  = '{0, 0,  23, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        bv[3]  = '{0, 0,  24, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        bv[4]  = '{0, 47, 31, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        bv[5]  = '{1, 0,  0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        bv[6]  = '{1, 27, 1,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        bv[7]  = '{1, 28, 1,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        bv[8]  = '{1, 31, 1,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        bv[9]  = '{1, 32, 1,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        bv[10] = '{1, 36, 1,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        bv[11] = '{1, 0,  28, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        bv[12] = '{1, 0,  29, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        bv[13] = '{1, 0,  31, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

        rst_a   = 1'b1;
        rst_b   = 1'b1;
        hoffs_a = 4'd0;
        voffs_a = 4'd0;
        hoffs_b = 4'd0;
        voffs_b = 4'd0;
        repeat (3) @(posedge clk);
        #1;
        check("a_reset_flags", {ce_a, hb_a, vb_a, hs_a, vs_a, vbs_a}, 0);
        check("a_reset_ph", ph_a, 0);
        check("a_reset_pv", pv_a, 0);
        check("b_reset_all", {ce_b, hb_b, vb_b, hs_b, vs_b, vbs_b, ph_b, pv_b}, 0);

        // ce_pix cadence and first PH steps after release
        @(negedge clk);
        rst_a = 1'b0;
        t_a   = 0;
        for (int c = 1; c <= 64; c++) begin
            @(posedge clk);
            #1;
            check("a_ce_cadence", ce_a, (c % 8 == 7));
            check("a_ph_start", ph_a, c / 8);
            check("a_pv_start", pv_a, 0);
        end
        t_a = 64;

        // line-level boundaries on the default raster
        for (int i = 0; i < 9; i++) begin
            a_goto(av[i].pv * 384 + av[i].ph);
            check("a_ph", ph_a, av[i].ph);
            check("a_pv", pv_a, av[i].pv);
            check("a_hblank", hb_a, av[i].hb);
            check("a_vblank", vb_a, av[i].vb);
            check("a_hsync", hs_a, av[i].hs);
            check("a_vsync", vs_a, av[i].vs);
            check("a_vbl_start", vbs_a, av[i].vbs);
            check("a_ce_low", ce_a, 0);
            repeat (7) @(posedge clk);
            t_a += 7;
            #1;
            check("a_ph_hold", ph_a, av[i].ph);
            check("a_ce_high", ce_a, 1);
        end

        // async reset in the middle of hsync
        a_goto(384 + 300);
        check("a_pre_reset_hs", {hb_a, hs_a}, 2'b11);
        #1 rst_a = 1'b1;
        #1;
        check("a_async_flags", {ce_a, hb_a, vb_a, hs_a, vs_a, vbs_a}, 0);
        check("a_async_ph", ph_a, 0);
        check("a_async_pv", pv_a, 0);
        repeat (3) @(posedge clk);
        #2 rst_a = 1'b0;
        for (int c = 1; c <= 16; c++) begin
            @(posedge clk);
            #1;
            check("a_ce_restart", ce_a, (c % 8 == 7));
            check("a_ph_restart", ph_a, c / 8);
        end

        // instance B: frame-level behaviour with a mid-frame trim change
        @(negedge clk);
        rst_b = 1'b0;
        t_b   = 0;
        b_goto(BFRAME / 2);
        hoffs_b = 4'b1000;
        voffs_b = 4'b0111;
        for (int i = 0; i < 14; i++) begin
            b_goto(8 * (bv[i].fr * BH_TOTAL * BV_TOTAL + bv[i].pv * BH_TOTAL + bv[i].ph));
            check("b_hblank", hb_b, bv[i].hb);
            check("b_vblank", vb_b, bv[i].vb);
            check("b_hsync", hs_b, bv[i].hs);
            check("b_vsync", vs_b, bv[i].vs);
            check("b_vbl_start", vbs_b, bv[i].vbs);
        end

        // random trims, changed every ~1000 cycles through frame 4
        while (t_b < 5 * BFRAME) begin
            b_goto(t_b + int'($urandom_range(900, 1100)));
            hoffs_b = 4'($urandom);
            voffs_b = 4'($urandom);
        end

        // one vbl_start pulse per frame reached
        exp_vbs = 0;
        for (int n = 0; 8 * (n * BH_TOTAL * BV_TOTAL + BV_VIS * BH_TOTAL) <= t_b; n++) exp_vbs++;
        check("b_vbl_count", vbs_cnt, exp_vbs);

        // async reset deep in vblank, then trims must stay 0 until the next frame
        b_goto(5 * BFRAME + 8 * (21 * BH_TOTAL + 37) + 3);
        hoffs_b = 4'b0111;
        voffs_b = 4'b0111;
        rst_b = 1'b1;
        #1;
        check("b_async_all", {ce_b, hb_b, vb_b, hs_b, vs_b, vbs_b, ph_b, pv_b}, 0);
        repeat (3) step_b();
        rst_b = 1'b0;
        b_goto(8 * (BH_TOTAL + 36));
        check("b_trim0_hs_on", hs_b, 1);
        b_goto(8 * (BH_TOTAL + 43));
        check("b_trim0_hs_off", hs_b, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
